// File: rtl/game_mode_ctrl.sv
// Round sequencer: countdown -> play -> finish (score commit handshake) -> result.
// Optional pause support is compiled in when the PAUSE_EN macro is defined.
module game_mode_ctrl #(
    parameter int COUNTDOWN_TICKS = 3,
    parameter int GAME_TICKS      = 30,
    parameter int RESULT_TICKS    = 5,
    localparam int TW             = $clog2(GAME_TICKS + 1)
) (
    input  logic          tb_clk,
    input  logic          tb_n_rst,
    input  logic          tick,
    input  logic          start,
    input  logic          pause,
    input  logic          note_hit,
    input  logic          note_miss,
    input  logic [3:0]    best_score,
    input  logic          commit_ack,
    output logic [2:0]    mode,
    output logic [3:0]    score,
    output logic [TW-1:0] timer,
    output logic          commit_req,
    output logic          new_best
);

    // state | meaning
    // IDLE      | waiting for start
    // COUNTDOWN | pre-round countdown, timer counts ticks
    // PLAY      | round running, hits/misses adjust score
    // PAUSE     | round frozen until next pause pulse (PAUSE_EN only)
    // FINISH    | commit_req held until commit_ack
    // RESULT    | result display, auto-return to IDLE or restart on start
    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_COUNTDOWN = 3'b001,
        S_PLAY      = 3'b010,
`ifdef PAUSE_EN
        S_PAUSE     = 3'b011,
`endif
        S_FINISH    = 3'b101,
        S_RESULT    = 3'b110
    } state_t;

    localparam logic [TW-1:0] CD_INIT   = TW'(COUNTDOWN_TICKS);
    localparam logic [TW-1:0] GAME_INIT = TW'(GAME_TICKS);
    localparam logic [TW-1:0] RES_INIT  = TW'(RESULT_TICKS);
    localparam logic [TW-1:0] ONE       = TW'(1);

    state_t        state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [3:0]    score_q, score_n;
    logic          new_best_q, new_best_n;
    logic          last_tick;

`ifndef PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    assign last_tick = tick && (timer_q == ONE);

    always_ff @(posedge tb_clk or negedge tb_n_rst) begin
        if (!tb_n_rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            score_q    <= '0;
            new_best_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            timer_q    <= timer_n;
            score_q    <= score_n;
            new_best_q <= new_best_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        timer_n    = timer_q;
        score_n    = score_q;
        new_best_n = new_best_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_COUNTDOWN;
                    timer_n    = CD_INIT;
                    score_n    = '0;
                    new_best_n = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                if (last_tick) begin
                    state_n = S_PLAY;
                    timer_n = GAME_INIT;
                end else if (tick) begin
                    timer_n = timer_q - ONE;
                end
            end
            S_PLAY: begin
                if (note_hit && !note_miss && score_q != 4'hF) begin
                    score_n = score_q + 4'd1;
                end else if (note_miss && !note_hit && score_q != 4'h0) begin
                    score_n = score_q - 4'd1;
                end
                if (last_tick) begin
                    state_n = S_FINISH;
                    timer_n = '0;
                end else if (tick) begin
                    timer_n = timer_q - ONE;
                end
`ifdef PAUSE_EN
                // A round-ending tick swallows a coincident pause.
                if (pause && !last_tick) begin
                    state_n = S_PAUSE;
                end
`endif
            end
`ifdef PAUSE_EN
            S_PAUSE: begin
                if (pause) begin
                    state_n = S_PLAY;
                end
            end
`endif
            S_FINISH: begin
                if (commit_ack) begin
                    new_best_n = (score_q > best_score);
                    state_n    = S_RESULT;
                    timer_n    = RES_INIT;
                end
            end
            S_RESULT: begin
                if (start) begin
                    state_n    = S_COUNTDOWN;
                    timer_n    = CD_INIT;
                    score_n    = '0;
                    new_best_n = 1'b0;
                end else if (last_tick) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else if (tick) begin
                    timer_n = timer_q - ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    assign mode       = state_q;
    assign score      = score_q;
    assign timer      = timer_q;
    assign commit_req = (state_q == S_FINISH);
    assign new_best   = new_best_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed bench for game_mode_ctrl: vector table for the opening of a round,
// hand-written sequences for saturation, commit handshake, pause, result and reset.
module tb_game_mode_ctrl;

    logic       tb_clk;
    logic       tb_n_rst;
    logic       tick, start, pause, note_hit, note_miss, commit_ack;
    logic [3:0] best_score;
    logic [2:0] mode;
    logic [3:0] score;
    logic [4:0] timer;
    logic       commit_req, new_best;

    int n_tests = 0;
    int n_fail  = 0;

    game_mode_ctrl #(
        .COUNTDOWN_TICKS(3),
        .GAME_TICKS(30),
        .RESULT_TICKS(5)
    ) dut (
        .tb_clk(tb_clk),
        .tb_n_rst(tb_n_rst),
        .tick(tick),
        .start(start),
        .pause(pause),
        .note_hit(note_hit),
        .note_miss(note_miss),
        .best_score(best_score),
        .commit_ack(commit_ack),
        .mode(mode),
        .score(score),
        .timer(timer),
        .commit_req(commit_req),
        .new_best(new_best)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic       s, p, t, h, m, a;
        logic [2:0] md;
        logic [3:0] sc;
        logic [4:0] tm;
        logic       rq, nb;
    } vec_t;

    vec_t vecs [15];

    task automatic step(input logic s, input logic p, input logic t,
                        input logic h, input logic m, input logic a);
        start = s; pause = p; tick = t; note_hit = h; note_miss = m; commit_ack = a;
        @(posedge tb_clk);
        #1;
        start = 1'b0; pause = 1'b0; tick = 1'b0;
        note_hit = 1'b0; note_miss = 1'b0; commit_ack = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [2:0] em, input logic [3:0] es,
                       input logic [4:0] et, input logic er, input logic en);
        n_tests++;
        if ({mode, score, timer, commit_req, new_best} !== {em, es, et, er, en}) begin
            n_fail++;
            $display("FAIL %s: got mode=%b score=%0d timer=%0d req=%b nb=%b, want mode=%b score=%0d timer=%0d req=%b nb=%b",
                     nm, mode, score, timer, commit_req, new_best, em, es, et, er, en);
        end
    endtask

    initial begin
        int e;
        //           s     p     t     h     m     a     mode    sc     tm      rq    nb
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 5'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 4'd0, 5'd0,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0, 5'd3,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0, 5'd2,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0, 5'd2,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0, 5'd2,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0, 5'd1,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'd0, 5'd30, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 4'd1, 5'd30, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'd2, 5'd29, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 4'd2, 5'd29, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4'd1, 5'd29, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4'd0, 5'd29, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4'd0, 5'd29, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 4'd0, 5'd29, 1'b0, 1'b0};

        start = 1'b0; pause = 1'b0; tick = 1'b0; note_hit = 1'b0;
        note_miss = 1'b0; commit_ack = 1'b0; best_score = 4'd4;
        tb_n_rst = 1'b0;
        #3;
        chk("reset", 3'b000, 4'd0, 5'd0, 1'b0, 1'b0);
        #4 tb_n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        chk("idle_after_reset", 3'b000, 4'd0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].h, vecs[i].m, vecs[i].a);
            chk($sformatf("vec%0d", i), vecs[i].md, vecs[i].sc, vecs[i].tm, vecs[i].rq, vecs[i].nb);
        end

        // Round 1: run down to timer=1 with four hits, final tick carries the fifth hit.
        for (int i = 0; i < 28; i++) begin
            step(1'b0, 1'b0, 1'b1, (i < 4), 1'b0, 1'b0);
            chk("r1_play_tick", 3'b010, 4'((i < 4) ? i + 1 : 4), 5'(28 - i), 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("r1_finish", 3'b101, 4'd5, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("r1_finish_wait", 3'b101, 4'd5, 5'd0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("r1_ack_best4", 3'b110, 4'd5, 5'd5, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("r1_result_ack_ignored", 3'b110, 4'd5, 5'd5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("r1_result_tick", 3'b110, 4'd5, 5'(4 - i), 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r1_result_to_idle", 3'b000, 4'd5, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("r1_idle_score_kept", 3'b000, 4'd5, 5'd0, 1'b0, 1'b1);

        // Round 2: saturation, pause, pause+final tick, no new best.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_start", 3'b001, 4'd0, 5'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_cd_1", 3'b001, 4'd0, 5'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_play", 3'b010, 4'd0, 5'd30, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("r2_hit_sat", 3'b010, 4'((i + 1 > 15) ? 15 : i + 1), 5'd30, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            e = 14 - i;
            if (e < 0) e = 0;
            chk("r2_miss_sat", 3'b010, 4'(e), 5'd30, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("r2_five_hits", 3'b010, 4'd5, 5'd30, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("r2_hit_and_miss", 3'b010, 4'd5, 5'd30, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("r2_tick", 3'b010, 4'd5, 5'(29 - i), 1'b0, 1'b0);
        end
`ifdef PAUSE_EN
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_pause", 3'b011, 4'd5, 5'd12, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("r2_paused_frozen", 3'b011, 4'd5, 5'd12, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("r2_paused_start", 3'b011, 4'd5, 5'd12, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_resume", 3'b010, 4'd5, 5'd12, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_pause_with_tick", 3'b011, 4'd5, 5'd11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_resume2", 3'b010, 4'd5, 5'd11, 1'b0, 1'b0);
`else
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_pause_ignored", 3'b010, 4'd5, 5'd12, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_pause_tick_ignored", 3'b010, 4'd5, 5'd11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_pause_ignored2", 3'b010, 4'd5, 5'd11, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("r2_tick_end", 3'b010, 4'd5, 5'(10 - i), 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_pause_final_tick", 3'b101, 4'd5, 5'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r2_finish_pause", 3'b101, 4'd5, 5'd0, 1'b1, 1'b0);
        best_score = 4'd5;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("r2_ack_best5", 3'b110, 4'd5, 5'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_result_t1", 3'b110, 4'd5, 5'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_start_beats_tick", 3'b001, 4'd0, 5'd3, 1'b0, 1'b0);

        // Round 3: asynchronous reset mid-play.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("r3_play_score7", 3'b010, 4'd7, 5'd30, 1'b0, 1'b0);
        #2 tb_n_rst = 1'b0;
        #1;
        chk("r3_async_reset", 3'b000, 4'd0, 5'd0, 1'b0, 1'b0);
        #2 tb_n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        chk("r3_after_reset", 3'b000, 4'd0, 5'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_mode_ctrl.md
Name: game_mode_ctrl

Overview:
- Top-level game sequencer. Drives the 3-bit mode bus and the 4-bit running score consumed by high_score_check.
- Runs each round through countdown, play, finish and result phases, timed by an external tick strobe.
- At round end, a req/ack handshake commits the final score to the high-score tracker. A new-best flag is latched for the display.

Parameters:
- COUNTDOWN_TICKS, 3: ticks spent in COUNTDOWN before play starts; must be >= 1.
- GAME_TICKS, 30: ticks in one PLAY round; must be >= 1.
- RESULT_TICKS, 5: ticks RESULT is held before auto-return to IDLE; must be >= 1.

Ports:
- tb_clk  input  1  system clock, 12 MHz.
- tb_n_rst  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle timebase strobe.
- start  input  1  one-cycle pulse, synchronized and debounced upstream.
- pause  input  1  one-cycle pulse, synchronized and debounced upstream.
- note_hit  input  1  one-cycle pulse: note played correctly.
- note_miss  input  1  one-cycle pulse: note missed.
- best_score  input  4  current highest_score from high_score_check.
- commit_ack  input  1  high-score tracker has sampled score.
- mode  output  3  000 IDLE, 001 COUNTDOWN, 010 PLAY, 011 PAUSE, 101 FINISH, 110 RESULT.
- score  output  4  running score.
- timer  output  $clog2(GAME_TICKS+1)  ticks remaining in current phase.
- commit_req  output  1  score valid for commit.
- new_best  output  1  last committed score beat best_score.

Behaviour:
- Reset (async, tb_n_rst=0): mode=IDLE, score=0, timer=0, commit_req=0, new_best=0. All state is registered. Outputs change only on posedge tb_clk.
- IDLE:
  - start -> COUNTDOWN next cycle; timer=COUNTDOWN_TICKS; score=0; new_best=0.
  - tick, hit, miss and pause are ignored.
- COUNTDOWN:
  - Each tick decrements timer.
  - A tick while timer==1 -> PLAY; timer=GAME_TICKS.
  - start and pause are ignored.
- PLAY:
  - note_hit alone: score+1, saturating at 15.
  - note_miss alone: score-1, saturating at 0.
  - hit and miss in the same cycle: no change.
  - Each tick decrements timer. A tick while timer==1 -> FINISH, timer=0; a hit/miss in that same cycle still updates score.
  - pause (no tick) -> PAUSE.
  - pause and tick in the same cycle: the tick is processed first. If it ends the round, go to FINISH and drop the pause; otherwise go to PAUSE with the decremented timer.
- PAUSE:
  - timer and score are frozen; tick, hit, miss and start are ignored.
  - pause -> PLAY.
- FINISH:
  - commit_req=1 from the first FINISH cycle; score is held stable while commit_req=1.
  - The cycle commit_ack=1 is sampled: new_best <= (score > best_score), unsigned; commit_req=0 next cycle; -> RESULT; timer=RESULT_TICKS.
  - No timeout: the state waits indefinitely for commit_ack.
  - commit_ack outside FINISH is ignored.
- RESULT:
  - score and new_best are held.
  - Each tick decrements timer. A tick while timer==1 -> IDLE; score is kept until the next start.
  - start -> COUNTDOWN directly, same actions as from IDLE. start wins over a simultaneous final tick.
- Latency: every state transition takes effect one cycle after the qualifying input is sampled.
- Unused mode encodings 100 and 111 are never driven. An illegal internal state recovers to IDLE on the next clock.
- Reset asserted mid-round, including during FINISH with commit_req=1, returns to reset values immediately. No commit is issued.

Optional Feature:
- Macro PAUSE_EN.
- Defined: PAUSE behaves as described above.
- Undefined: the pause input is ignored in all states and encoding 011 is never produced. The PAUSE state logic is not compiled.

Test Plan:
- Reset during PLAY with score=7 -> mode=000, score=0, commit_req=0, new_best=0 asynchronously.
- start, then 3 ticks, then 30 ticks with 5 note_hit in between -> mode 001 then 010 then 101; commit_req=1 with score=5 held.
- In FINISH with best_score=4 and commit_ack raised after 3 cycles -> score stable during the wait, commit_req drops next cycle, new_best=1, mode=110, timer=5; with best_score=5 instead -> new_best=0.
- PLAY: 17 hits -> score saturates at 15; then 20 misses -> score=0; hit and miss in the same cycle -> no change.
- PAUSE_EN defined: pause in PLAY at timer=12, then 4 ticks and hits -> mode=011, timer=12 and score unchanged; second pause returns to 010. PAUSE_EN undefined: pause has no effect.
- RESULT: 5 ticks -> IDLE, score retained. Separately, start in the same cycle as the final RESULT tick -> COUNTDOWN, score=0.
